// File: rtl/wdt_reset_escalator.sv
// wdt_reset_escalator
// Turns the watchdog's timeout level into an escalation sequence:
// grace window with an early-warning flag, then a fixed-width system
// reset request pulse, then a hold-off until the timeout level clears.
// Two saturating event counters record issued resets and recovered
// grace windows.
//
// Optional build macro: WDT_ESC_LOCK_EN
//   Defined   - a sticky lock bit, set by the first cycle with arm=1,
//               forces the block armed until rst; state_out grows to
//               3 bits with the lock in the MSB.
//   Undefined - arm is used directly; state_out is 2 bits.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a timeout entry edge while armed
// GRACE   | grace window running, warn_irq high, a tap returns to IDLE
// ASSERT  | reset_req high for PULSE_CYCLES cycles, inputs ignored
// HOLDOFF | pulse done, waiting for timeout_in to clear before re-arming

module wdt_reset_escalator #(
    parameter int GRACE_W      = 16,
    parameter int PULSE_CYCLES = 64,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               timeout_in,
    input  logic [GRACE_W-1:0] grace_cycles,
    input  logic               cnt_clr,
    output logic               warn_irq,
    output logic               reset_req,
`ifdef WDT_ESC_LOCK_EN
    output logic [2:0]         state_out,
`else
    output logic [1:0]         state_out,
`endif
    output logic [CNT_W-1:0]   reset_count,
    output logic [CNT_W-1:0]   recover_count
);

    localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYCLES);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(1);
    localparam logic [GRACE_W-1:0] GRACE_LAST = GRACE_W'(1);
    localparam logic [GRACE_W-1:0] GRACE_ZERO = '0;
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRACE   = 2'b01,
        ASSERT  = 2'b10,
        HOLDOFF = 2'b11
    } state_t;

    state_t             state;
    logic               timeout_q;
    logic [GRACE_W-1:0] grace_cnt;
    logic [PULSE_W-1:0] pulse_cnt;

    logic               arm_eff;
    logic               entry_edge;
    logic               tap_hit;
    logic               pulse_done;

`ifdef WDT_ESC_LOCK_EN
    logic lock_q;

    // Sticky lock: once software has armed the block it cannot disarm it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (arm) begin
            lock_q <= 1'b1;
        end
    end

    assign arm_eff   = arm | lock_q;
    assign state_out = {lock_q, state};
`else
    assign arm_eff   = arm;
    assign state_out = state;
`endif

    // Delayed copy of the timeout level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_in;
        end
    end

    // Only a fresh rising edge starts escalation; a level that was already
    // high (e.g. while disarmed or during hold-off) never retriggers.
    assign entry_edge = timeout_in & ~timeout_q;

    // Disarm has priority over a tap, so a disarm never counts as a recovery.
    assign tap_hit    = (state == GRACE) & arm_eff & ~timeout_in;
    assign pulse_done = (state == ASSERT) & (pulse_cnt == PULSE_LAST);

    // Saturating event counters; a clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            reset_count   <= '0;
            recover_count <= '0;
        end else if (cnt_clr) begin
            reset_count   <= '0;
            recover_count <= '0;
        end else begin
            if (pulse_done && (reset_count != CNT_MAX)) begin
                reset_count <= reset_count + 1'b1;
            end
            if (tap_hit && (recover_count != CNT_MAX)) begin
                recover_count <= recover_count + 1'b1;
            end
        end
    end

    // Escalation FSM; warn_irq and reset_req are registered with the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grace_cnt <= '0;
            pulse_cnt <= '0;
            warn_irq  <= 1'b0;
            reset_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (entry_edge && arm_eff) begin
                        if (grace_cycles != GRACE_ZERO) begin
                            state     <= GRACE;
                            grace_cnt <= grace_cycles;
                            warn_irq  <= 1'b1;
                        end else begin
                            state     <= ASSERT;
                            pulse_cnt <= PULSE_LOAD;
                            reset_req <= 1'b1;
                        end
                    end
                end

                GRACE: begin
                    grace_cnt <= grace_cnt - 1'b1;
                    if (!arm_eff || !timeout_in) begin
                        state    <= IDLE;
                        warn_irq <= 1'b0;
                    end else if (grace_cnt == GRACE_LAST) begin
                        state     <= ASSERT;
                        pulse_cnt <= PULSE_LOAD;
                        warn_irq  <= 1'b0;
                        reset_req <= 1'b1;
                    end
                end

                ASSERT: begin
                    pulse_cnt <= pulse_cnt - 1'b1;
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= HOLDOFF;
                        reset_req <= 1'b0;
                    end
                end

                HOLDOFF: begin
                    if (!arm_eff || !timeout_in) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    warn_irq  <= 1'b0;
                    reset_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wdt_reset_escalator.sv
// Testbench for wdt_reset_escalator: directed scenarios plus a randomized
// run checked cycle by cycle against a behavioural model that tracks the
// remaining warning and pulse cycles rather than an explicit state machine.
module tb_wdt_reset_escalator;

    localparam int GRACE_W = 16;
    localparam int PULSE   = 64;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef WDT_ESC_LOCK_EN
    localparam int SW = 3;
`else
    localparam int SW = 2;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               arm;
    logic               timeout_in;
    logic [GRACE_W-1:0] grace_cycles;
    logic               cnt_clr;
    logic               warn_irq;
    logic               reset_req;
    logic [SW-1:0]      state_out;
    logic [CNT_W-1:0]   reset_count;
    logic [CNT_W-1:0]   recover_count;

    int compared   = 0;
    int mismatched = 0;

    // Model: time left in the warning window, time left in the pulse,
    // waiting-for-clear flag, last timeout level, lock, event tallies.
    int m_warn_left;
    int m_pulse_left;
    bit m_hold;
    bit m_prev_to;
    bit m_lock;
    int m_rst_cnt;
    int m_rec_cnt;

    wdt_reset_escalator #(
        .GRACE_W(GRACE_W),
        .PULSE_CYCLES(PULSE),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arm(arm),
        .timeout_in(timeout_in),
        .grace_cycles(grace_cycles),
        .cnt_clr(cnt_clr),
        .warn_irq(warn_irq),
        .reset_req(reset_req),
        .state_out(state_out),
        .reset_count(reset_count),
        .recover_count(recover_count)
    );

    always #5 clk = ~clk;

    function automatic void model_update();
        bit arm_e;
        arm_e = arm | m_lock;
        if (rst) begin
            m_warn_left  = 0;
            m_pulse_left = 0;
            m_hold       = 1'b0;
            m_prev_to    = 1'b0;
            m_lock       = 1'b0;
            m_rst_cnt    = 0;
            m_rec_cnt    = 0;
        end else begin
            if (m_warn_left > 0) begin
                if (!arm_e) begin
                    m_warn_left = 0;
                end else if (!timeout_in) begin
                    m_warn_left = 0;
                    if (m_rec_cnt < CNT_MAX) m_rec_cnt++;
                end else if (m_warn_left == 1) begin
                    m_warn_left  = 0;
                    m_pulse_left = PULSE;
                end else begin
                    m_warn_left--;
                end
            end else if (m_pulse_left > 0) begin
                if (m_pulse_left == 1) begin
                    m_pulse_left = 0;
                    m_hold       = 1'b1;
                    if (m_rst_cnt < CNT_MAX) m_rst_cnt++;
                end else begin
                    m_pulse_left--;
                end
            end else if (m_hold) begin
                if (!arm_e || !timeout_in) m_hold = 1'b0;
            end else if (arm_e && timeout_in && !m_prev_to) begin
                if (grace_cycles != 0) m_warn_left = int'(grace_cycles);
                else m_pulse_left = PULSE;
            end
            if (cnt_clr) begin
                m_rst_cnt = 0;
                m_rec_cnt = 0;
            end
`ifdef WDT_ESC_LOCK_EN
            m_lock = m_lock | arm;
`endif
            m_prev_to = timeout_in;
        end
    endfunction

    function automatic logic [SW-1:0] model_state();
        int s;
        s = 0;
        if (m_warn_left > 0) s = 1;
        else if (m_pulse_left > 0) s = 2;
        else if (m_hold) s = 3;
        if (m_lock) s = s + 4;
        return SW'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; timeout_in = 1'b0; cnt_clr = 1'b0; grace_cycles = '0;
        step();
        step();
        rst = 1'b0;
        step();
        compared++;
        if (warn_irq !== 1'b0) begin mismatched++; $display("FAIL reset_warn got=%b exp=0", warn_irq); end
        compared++;
        if (reset_req !== 1'b0) begin mismatched++; $display("FAIL reset_req got=%b exp=0", reset_req); end
        compared++;
        if (state_out !== '0) begin mismatched++; $display("FAIL reset_state got=%0d exp=0", state_out); end
        compared++;
        if (reset_count !== '0) begin mismatched++; $display("FAIL reset_rcnt got=%0d exp=0", reset_count); end
        compared++;
        if (recover_count !== '0) begin mismatched++; $display("FAIL reset_vcnt got=%0d exp=0", recover_count); end
    endtask

    task automatic test_full_escalation();
        int w, r, k;
        do_rst();
        arm = 1'b1; grace_cycles = 16'd10; timeout_in = 1'b0;
        step();
        timeout_in = 1'b1;
        w = 0; r = 0;
        for (k = 0; k < 300; k++) begin
            step();
            if (warn_irq === 1'b1) w++;
            if (reset_req === 1'b1) r++;
            if (state_out[1:0] === 2'b11) break;
        end
        compared++;
        if (k >= 300) begin mismatched++; $display("FAIL esc_holdoff_reached got=timeout exp=holdoff"); end
        compared++;
        if (w != 10) begin mismatched++; $display("FAIL esc_warn_len got=%0d exp=10", w); end
        compared++;
        if (r != PULSE) begin mismatched++; $display("FAIL esc_pulse_len got=%0d exp=%0d", r, PULSE); end
        compared++;
        if (reset_count !== 8'd1) begin mismatched++; $display("FAIL esc_rcnt got=%0d exp=1", reset_count); end
        repeat (5) step();
        compared++;
        if (state_out[1:0] !== 2'b11) begin mismatched++; $display("FAIL esc_holdoff got=%0d exp=3", state_out[1:0]); end
        timeout_in = 1'b0;
        step();
        compared++;
        if (state_out[1:0] !== 2'b00) begin mismatched++; $display("FAIL esc_idle got=%0d exp=0", state_out[1:0]); end
    endtask

    task automatic test_recovery();
        int r;
        do_rst();
        arm = 1'b1; grace_cycles = 16'd100; timeout_in = 1'b0;
        step();
        timeout_in = 1'b1;
        r = 0;
        repeat (40) begin
            step();
            if (reset_req === 1'b1) r++;
        end
        compared++;
        if (warn_irq !== 1'b1) begin mismatched++; $display("FAIL rec_warn_before got=%b exp=1", warn_irq); end
        timeout_in = 1'b0;
        step();
        if (reset_req === 1'b1) r++;
        compared++;
        if (warn_irq !== 1'b0) begin mismatched++; $display("FAIL rec_warn_drop got=%b exp=0", warn_irq); end
        compared++;
        if (r != 0) begin mismatched++; $display("FAIL rec_no_pulse got=%0d exp=0", r); end
        compared++;
        if (recover_count !== 8'd1) begin mismatched++; $display("FAIL rec_vcnt got=%0d exp=1", recover_count); end
        compared++;
        if (state_out[1:0] !== 2'b00) begin mismatched++; $display("FAIL rec_state got=%0d exp=0", state_out[1:0]); end
    endtask

    task automatic test_zero_grace();
        int r;
        do_rst();
        arm = 1'b1; grace_cycles = '0; timeout_in = 1'b0;
        step();
        timeout_in = 1'b1;
        step();
        compared++;
        if (reset_req !== 1'b1) begin mismatched++; $display("FAIL zg_req_start got=%b exp=1", reset_req); end
        compared++;
        if (warn_irq !== 1'b0) begin mismatched++; $display("FAIL zg_warn got=%b exp=0", warn_irq); end
        r = 1;
        repeat (250) begin
            step();
            if (reset_req === 1'b1) r++;
        end
        compared++;
        if (r != PULSE) begin mismatched++; $display("FAIL zg_pulse_total got=%0d exp=%0d", r, PULSE); end
        compared++;
        if (state_out[1:0] !== 2'b11) begin mismatched++; $display("FAIL zg_stuck_state got=%0d exp=3", state_out[1:0]); end
        compared++;
        if (reset_count !== 8'd1) begin mismatched++; $display("FAIL zg_rcnt got=%0d exp=1", reset_count); end
    endtask

    task automatic test_saturation_clear();
        int c;
        do_rst();
        arm = 1'b1; grace_cycles = '0; timeout_in = 1'b0; cnt_clr = 1'b0;
        step();
        for (int n = 0; n < 260; n++) begin
            timeout_in = 1'b1;
            step();
            for (c = 0; c < 100 && !m_hold; c++) step();
            timeout_in = 1'b0;
            step();
        end
        compared++;
        if (reset_count !== 8'd255) begin mismatched++; $display("FAIL sat_rcnt got=%0d exp=255", reset_count); end
        compared++;
        if (recover_count !== 8'd0) begin mismatched++; $display("FAIL sat_vcnt got=%0d exp=0", recover_count); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        compared++;
        if (reset_count !== 8'd0) begin mismatched++; $display("FAIL clr_rcnt got=%0d exp=0", reset_count); end
        timeout_in = 1'b1;
        step();
        for (c = 0; c < 100 && !m_hold; c++) begin
            cnt_clr = (m_pulse_left == 1);
            step();
        end
        cnt_clr = 1'b0;
        compared++;
        if (reset_count !== 8'd0) begin mismatched++; $display("FAIL clr_wins got=%0d exp=0", reset_count); end
        compared++;
        if (state_out[1:0] !== 2'b11) begin mismatched++; $display("FAIL clr_state got=%0d exp=3", state_out[1:0]); end
        timeout_in = 1'b0;
        step();
    endtask

    task automatic test_disarm();
        int r;
        do_rst();
        arm = 1'b1; grace_cycles = 16'd20; timeout_in = 1'b0;
        step();
        timeout_in = 1'b1;
        repeat (5) step();
        arm = 1'b0;
        step();
        r = 0;
`ifdef WDT_ESC_LOCK_EN
        compared++;
        if (warn_irq !== 1'b1) begin mismatched++; $display("FAIL lock_warn got=%b exp=1", warn_irq); end
`else
        compared++;
        if (warn_irq !== 1'b0) begin mismatched++; $display("FAIL disarm_warn got=%b exp=0", warn_irq); end
        compared++;
        if (state_out !== 2'b00) begin mismatched++; $display("FAIL disarm_state got=%0d exp=0", state_out); end
`endif
        repeat (80) begin
            step();
            if (reset_req === 1'b1) r++;
        end
`ifdef WDT_ESC_LOCK_EN
        compared++;
        if (r != PULSE) begin mismatched++; $display("FAIL lock_pulse got=%0d exp=%0d", r, PULSE); end
`else
        compared++;
        if (r != 0) begin mismatched++; $display("FAIL disarm_pulse got=%0d exp=0", r); end
`endif
        compared++;
        if (recover_count !== 8'd0) begin mismatched++; $display("FAIL disarm_vcnt got=%0d exp=0", recover_count); end
        timeout_in = 1'b0;
        arm = 1'b1;
        step();
    endtask

    task automatic test_rst_mid_pulse();
        do_rst();
        arm = 1'b1; grace_cycles = 16'd3; timeout_in = 1'b0;
        step();
        timeout_in = 1'b1;
        step();
        timeout_in = 1'b0;
        step();
        compared++;
        if (recover_count !== 8'd1) begin mismatched++; $display("FAIL mid_pre_vcnt got=%0d exp=1", recover_count); end
        timeout_in = 1'b1;
        repeat (13) step();
        compared++;
        if (reset_req !== 1'b1) begin mismatched++; $display("FAIL mid_pre_req got=%b exp=1", reset_req); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if (reset_req !== 1'b0) begin mismatched++; $display("FAIL mid_req got=%b exp=0", reset_req); end
        compared++;
        if (recover_count !== 8'd0) begin mismatched++; $display("FAIL mid_vcnt got=%0d exp=0", recover_count); end
        compared++;
        if (state_out !== '0) begin mismatched++; $display("FAIL mid_state got=%0d exp=0", state_out); end
        timeout_in = 1'b0;
        step();
    endtask

    task automatic test_lost_edge();
        int w, r;
        do_rst();
        arm = 1'b0; grace_cycles = 16'd5; timeout_in = 1'b0;
        step();
        timeout_in = 1'b1;
        step();
        step();
        arm = 1'b1;
        w = 0; r = 0;
        repeat (20) begin
            step();
            if (warn_irq === 1'b1) w++;
            if (reset_req === 1'b1) r++;
        end
        compared++;
        if (w != 0 || r != 0) begin mismatched++; $display("FAIL lost_edge got=warn%0d/req%0d exp=0/0", w, r); end
        compared++;
        if (state_out[1:0] !== 2'b00) begin mismatched++; $display("FAIL lost_state got=%0d exp=0", state_out[1:0]); end
        timeout_in = 1'b0;
        step();
    endtask

    task automatic test_random();
        do_rst();
        for (int i = 0; i < 4000; i++) begin
            arm          = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 29) == 0) timeout_in = ~timeout_in;
            grace_cycles = GRACE_W'($urandom_range(0, 6));
            cnt_clr      = ($urandom_range(0, 49) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            step();
            compared++;
            if (warn_irq !== (m_warn_left > 0)) begin
                mismatched++; $display("FAIL rnd_warn cyc=%0d got=%b exp=%b", i, warn_irq, (m_warn_left > 0));
            end
            compared++;
            if (reset_req !== (m_pulse_left > 0)) begin
                mismatched++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, reset_req, (m_pulse_left > 0));
            end
            compared++;
            if (state_out !== model_state()) begin
                mismatched++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, state_out, model_state());
            end
            compared++;
            if (reset_count !== CNT_W'(m_rst_cnt)) begin
                mismatched++; $display("FAIL rnd_rcnt cyc=%0d got=%0d exp=%0d", i, reset_count, m_rst_cnt);
            end
            compared++;
            if (recover_count !== CNT_W'(m_rec_cnt)) begin
                mismatched++; $display("FAIL rnd_vcnt cyc=%0d got=%0d exp=%0d", i, recover_count, m_rec_cnt);
            end
        end
        rst = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_escalation();
        test_recovery();
        test_zero_grace();
        test_saturation_clear();
        test_disarm();
        test_rst_mid_pulse();
        test_lost_edge();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
